cdb_arbiter: RTL and testbench



---
 rtl/cdb_arbiter.sv | 112 +++++++++++
 tb/tb_cdb_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin selection among functional-unit result
// ports, a registered CDB broadcast stage and a saturating contention counter.
module cdb_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 6,
    parameter int unsigned SRC_WIDTH  = $clog2(NUM_REQ),
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]   req_tag,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           flush,
    output logic                           cdb_valid,
    output logic [TAG_WIDTH-1:0]           cdb_tag,
    output logic [DATA_WIDTH-1:0]          cdb_data,
    output logic [SRC_WIDTH-1:0]           cdb_src,
    output logic [CNT_WIDTH-1:0]           conflict_cnt
);

    // One extra bit so ptr + offset cannot overflow before the modulo wrap.
    localparam logic [SRC_WIDTH:0]   NumReqW = (SRC_WIDTH+1)'(NUM_REQ);
    localparam logic [SRC_WIDTH-1:0] LastIdx = SRC_WIDTH'(NUM_REQ - 1);
    localparam logic [CNT_WIDTH-1:0] CntMax  = {CNT_WIDTH{1'b1}};

    logic [SRC_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
    logic                  cdb_valid_q;
    logic [TAG_WIDTH-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_WIDTH-1:0] cdb_data_q, cdb_data_d;
    logic [SRC_WIDTH-1:0]  cdb_src_q, cdb_src_d;
    logic [CNT_WIDTH-1:0]  conflict_q, conflict_d;

    logic [NUM_REQ-1:0]    grant_vec;
    logic [SRC_WIDTH-1:0]  grant_idx;
    logic                  grant_any;
    logic [SRC_WIDTH:0]    cand_sum;
    logic [SRC_WIDTH-1:0]  cand_idx;
    logic                  multi_req;

    // Round-robin search from rr_ptr upward with an explicit wrap at NUM_REQ-1.
    always_comb begin
        grant_vec = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand_sum  = '0;
        cand_idx  = '0;
        if (!rst && !flush) begin
            for (int off = 0; off < int'(NUM_REQ); off++) begin
                cand_sum = {1'b0, rr_ptr_q} + (SRC_WIDTH+1)'(off);
                if (cand_sum >= NumReqW) begin
                    cand_sum = cand_sum - NumReqW;
                end
                cand_idx = cand_sum[SRC_WIDTH-1:0];
                if (!grant_any && req_valid[cand_idx]) begin
                    grant_any           = 1'b1;
                    grant_idx           = cand_idx;
                    grant_vec[cand_idx] = 1'b1;
                end
            end
        end
    end

    assign req_ready = grant_vec;

    // Next-state for pointer, broadcast payload and contention counter.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        cdb_tag_d  = cdb_tag_q;
        cdb_data_d = cdb_data_q;
        cdb_src_d  = cdb_src_q;
        conflict_d = conflict_q;
        multi_req  = ($countones(req_valid) > 1);
        if (grant_any) begin
            rr_ptr_d   = (grant_idx == LastIdx) ? '0 : grant_idx + SRC_WIDTH'(1);
            cdb_tag_d  = req_tag[int'(grant_idx) * TAG_WIDTH +: TAG_WIDTH];
            cdb_data_d = req_data[int'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
            cdb_src_d  = grant_idx;
        end
        if (!flush && multi_req && (conflict_q != CntMax)) begin
            conflict_d = conflict_q + CNT_WIDTH'(1);
        end
    end

    // State registers; tag/data/src hold when no grant so the bus stays quiet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
            conflict_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= grant_any;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_src_q   <= cdb_src_d;
            conflict_q  <= conflict_d;
        end
    end

    assign cdb_valid    = cdb_valid_q;
    assign cdb_tag      = cdb_tag_q;
    assign cdb_data     = cdb_data_q;
    assign cdb_src      = cdb_src_q;
    assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a 4-port instance checked through a CDB
// scoreboard, and a 3-port / 4-bit-counter instance for wrap and saturation.
module tb_cdb_arbiter;

    typedef struct packed {
        logic        v;
        logic [5:0]  t;
        logic [31:0] d;
        logic [1:0]  s;
    } cdb_t;

    logic clk;
    logic rst;
    logic flush;

    // Four-port instance
    logic [3:0]   v;
    logic [5:0]   tg [4];
    logic [31:0]  dt [4];
    logic [23:0]  req_tag;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         cdb_valid;
    logic [5:0]   cdb_tag;
    logic [31:0]  cdb_data;
    logic [1:0]   cdb_src;
    logic [15:0]  conflict_cnt;

    // Three-port instance with a 4-bit counter
    logic [2:0]   v3;
    logic [17:0]  tag3;
    logic [95:0]  data3;
    logic [2:0]   ready3;
    logic         valid3;
    logic [5:0]   ctag3;
    logic [31:0]  cdata3;
    logic [1:0]   src3;
    logic [3:0]   conflict3;
    logic         flush3;

    int   total = 0;
    int   bad   = 0;
    cdb_t exp_q[$];
    logic [15:0] m_cnt;
    logic [3:0]  m3;
    logic        refresh;

    assign req_tag  = {tg[3], tg[2], tg[1], tg[0]};
    assign req_data = {dt[3], dt[2], dt[1], dt[0]};

    cdb_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .TAG_WIDTH(6), .CNT_WIDTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (v),
        .req_tag      (req_tag),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .flush        (flush),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .cdb_src      (cdb_src),
        .conflict_cnt (conflict_cnt)
    );

    cdb_arbiter #(.NUM_REQ(3), .DATA_WIDTH(32), .TAG_WIDTH(6), .CNT_WIDTH(4)) dut3 (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (v3),
        .req_tag      (tag3),
        .req_data     (data3),
        .req_ready    (ready3),
        .flush        (flush3),
        .cdb_valid    (valid3),
        .cdb_tag      (ctag3),
        .cdb_data     (cdata3),
        .cdb_src      (src3),
        .conflict_cnt (conflict3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of the 4-port instance: sample at negedge, then step past posedge.
    task automatic cycle(input logic [3:0] exp_ready);
        cdb_t e;
        int   g;
        g = -1;
        @(negedge clk);
        if (rst) begin
            chk("rst_ready", 64'(req_ready), 64'(0));
            chk("rst_valid", 64'(cdb_valid), 64'(0));
            chk("rst_tag",   64'(cdb_tag),   64'(0));
            chk("rst_data",  64'(cdb_data),  64'(0));
            chk("rst_src",   64'(cdb_src),   64'(0));
            chk("rst_cnt",   64'(conflict_cnt), 64'(0));
            exp_q.delete();
            exp_q.push_back('0);
            m_cnt = '0;
        end else begin
            if (exp_q.size() == 0) begin
                chk("sb_empty", 64'(1), 64'(0));
                e = '0;
            end else begin
                e = exp_q.pop_front();
            end
            chk("cdb_valid", 64'(cdb_valid), 64'(e.v));
            chk("cdb_tag",   64'(cdb_tag),   64'(e.t));
            chk("cdb_data",  64'(cdb_data),  64'(e.d));
            chk("cdb_src",   64'(cdb_src),   64'(e.s));
            chk("req_ready", 64'(req_ready), 64'(exp_ready));
            chk("conflict",  64'(conflict_cnt), 64'(m_cnt));
            for (int i = 0; i < 4; i++) if (exp_ready[i]) g = i;
            if (g >= 0) exp_q.push_back('{1'b1, tg[g], dt[g], 2'(g)});
            else        exp_q.push_back('{1'b0, e.t, e.d, e.s});
            if (!flush && $countones(v) >= 2 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        @(posedge clk);
        #1;
        // Granted requester re-raises valid with a fresh result.
        if (refresh && g >= 0) begin
            tg[g] = tg[g] + 6'd4;
            dt[g] = $urandom;
        end
    endtask

    // One clock of the 3-port instance.
    task automatic cyc3(input logic [2:0] exp_ready, input logic exp_valid, input int exp_src);
        @(negedge clk);
        chk("r3_ready", 64'(ready3), 64'(exp_ready));
        chk("r3_valid", 64'(valid3), 64'(exp_valid));
        if (exp_valid) begin
            chk("r3_src", 64'(src3), 64'(exp_src));
            chk("r3_tag", 64'(ctag3), 64'(6'h10 + 6'(exp_src)));
        end
        chk("r3_cnt", 64'(conflict3), 64'(m3));
        if ($countones(v3) >= 2 && m3 != 4'hF) m3 = m3 + 4'd1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int prev;
        int gi;
        logic [2:0] er;
        rst     = 1'b1;
        flush   = 1'b0;
        flush3  = 1'b0;
        refresh = 1'b0;
        v       = '0;
        v3      = '0;
        tag3    = {6'h12, 6'h11, 6'h10};
        data3   = {32'h3333, 32'h2222, 32'h1111};
        m_cnt   = '0;
        m3      = '0;
        for (int i = 0; i < 4; i++) begin
            tg[i] = 6'(i + 1);
            dt[i] = 32'h1000 * (i + 1);
        end

        // Power-on reset
        cycle(4'b0000);
        cycle(4'b0000);
        rst = 1'b0;

        // Single requester: full throughput, same payload each cycle
        v = 4'b0100;
        tg[2] = 6'h15;
        dt[2] = 32'hDEADBEEF;
        cycle(4'b0100);
        cycle(4'b0100);
        cycle(4'b0100);
        v = 4'b0000;
        cycle(4'b0000);

        // Contention starting from ptr=3, then reset mid-stream
        refresh = 1'b1;
        v = 4'b1111;
        cycle(4'b1000);
        cycle(4'b0001);
        rst = 1'b1;
        cycle(4'b0000);
        rst = 1'b0;
        cycle(4'b0001);
        cycle(4'b0010);
        cycle(4'b0100);
        cycle(4'b1000);
        cycle(4'b0001);

        // Flush: unit 1 granted, then flush, then unit 3 wins once flush drops
        refresh = 1'b0;
        v = 4'b1010;
        cycle(4'b0010);
        flush = 1'b1;
        cycle(4'b0000);
        flush = 1'b0;
        cycle(4'b1000);
        cycle(4'b0010);
        v = 4'b0000;
        cycle(4'b0000);
        cycle(4'b0000);

        // Three-port wrap: move ptr to 2, then all valid -> 2, 0, 1
        v3 = 3'b010;
        cyc3(3'b010, 1'b0, 0);
        v3 = 3'b111;
        cyc3(3'b100, 1'b1, 1);
        cyc3(3'b001, 1'b1, 2);
        cyc3(3'b010, 1'b1, 0);
        prev = 1;
        for (int i = 0; i < 20; i++) begin
            gi = (i % 3 == 0) ? 2 : ((i % 3 == 1) ? 0 : 1);
            er = 3'b001 << gi;
            cyc3(er, 1'b1, prev);
            prev = gi;
        end
        v3 = 3'b000;
        cyc3(3'b000, 1'b1, prev);
        chk("r3_sat", 64'(conflict3), 64'(4'hF));
        cyc3(3'b000, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
